sport_abuf_steal_ctl: RTL

- Autobuffer steal controller for the two serial ports (SPORT0/1, TX and RX).
- Collects per-channel service requests, arbitrates them and requests a DAG steal cycle from the core.
- Issues the one-hot steal acknowledges (T0sack/T1sack/R0sack/R1sack) to the DAG modulo unit.
- Consumes the registered wrap flags that unit returns and turns them into autobuffer-complete interrupts. It also flags request overruns.

---
 rtl/sport_abuf_steal_ctl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sport_abuf_steal_ctl.sv
// Autobuffer steal controller for SPORT0/1 TX and RX channels.
// Collects per-channel service requests and arbitrates them. It requests a DAG steal cycle from
// the core and issues a one-hot steal acknowledge to the DAG modulo unit. The registered wrap
// flag returned by that unit is turned into a one-cycle autobuffer-complete interrupt.
// Channel order on every 4-bit bus: bit0=R0, bit1=T0, bit2=R1, bit3=T1.
//
// Ports:
//   DSPCLK     clock, rising edge
//   RST        asynchronous active-high reset
//   ABUF_EN    per-channel autobuffer enables
//   SREQ       one-cycle service-request pulses
//   STEAL_GNT  core grants the requested steal cycle
//   *wrap      registered wrap flags, valid the cycle after the matching sack
//   OVR_CLR    clears OVR and STEAL_TO
//   STEAL_REQ  steal-cycle request (registered)
//   *sack      one-hot steal acknowledge, one cycle wide (registered)
//   ABUF_IRQ   one-cycle autobuffer-complete interrupt per channel
//   OVR        sticky request-overrun flags
//   STEAL_TO   sticky grant-timeout flag
module sport_abuf_steal_ctl #(
  parameter int unsigned PRIO_ROTATE = 0,
  parameter int unsigned GNT_TIMEOUT = 15
) (
  input  logic       DSPCLK,
  input  logic       RST,
  input  logic [3:0] ABUF_EN,
  input  logic [3:0] SREQ,
  input  logic       STEAL_GNT,
  input  logic       T0wrap,
  input  logic       T1wrap,
  input  logic       R0wrap,
  input  logic       R1wrap,
  input  logic       OVR_CLR,
  output logic       STEAL_REQ,
  output logic       T0sack,
  output logic       T1sack,
  output logic       R0sack,
  output logic       R1sack,
  output logic [3:0] ABUF_IRQ,
  output logic [3:0] OVR,
  output logic       STEAL_TO
);

  typedef enum logic [1:0] {StIdle, StReq, StSack, StWait} state_e;

  state_e     state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] ch_q, ch_d;
  logic [3:0] cnt_q, cnt_d;
  logic       req_q, req_d;
  logic [3:0] sack_q, sack_d;
  logic [3:0] irq_q, irq_d;
  logic [3:0] ovr_q, ovr_d;
  logic       to_q, to_d;

  logic [3:0] wrap;
  logic [3:0] eff_pending;
  logic [3:0] set_req;
  logic [3:0] clr_req;
  logic [3:0] ovr_set;
  logic [1:0] search_start;
  logic [1:0] winner;
  logic [4:0] cnt_inc;
  logic       grant;
  logic       to_set;

  // First requesting channel at or after start, wrapping modulo 4.
  function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    res   = start;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && req[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign wrap         = {T1wrap, R1wrap, T0wrap, R0wrap};
  // A disabled channel no longer competes even before its pending bit is cleared.
  assign eff_pending  = pending_q & ABUF_EN;
  assign search_start = (PRIO_ROTATE != 0) ? ptr_q + 2'd1 : 2'd0;
  assign winner       = pick(eff_pending, search_start);
  assign cnt_inc      = {1'b0, cnt_q} + 5'd1;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant   = 1'b0;
    to_set  = 1'b0;
    irq_d   = 4'b0000;
    unique case (state_q)
      StIdle: begin
        if (|eff_pending) state_d = StReq;
      end
      StReq: begin
        if (eff_pending == 4'b0000) begin
          // Everything was disabled under us; a grant this cycle is ignored.
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else if (STEAL_GNT) begin
          grant   = 1'b1;
          ch_d    = winner;
          if (PRIO_ROTATE != 0) ptr_d = winner;
          cnt_d   = 4'd0;
          state_d = StSack;
        end else begin
          cnt_d  = cnt_inc[4] ? cnt_q : cnt_inc[3:0];
          to_set = (GNT_TIMEOUT != 0) && (cnt_inc == 5'(GNT_TIMEOUT));
        end
      end
      StSack: begin
        state_d = StWait;
      end
      StWait: begin
        // Only the latched channel's wrap flag is meaningful here.
        if (wrap[ch_q]) irq_d[ch_q] = 1'b1;
        state_d = (|eff_pending) ? StReq : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    set_req   = SREQ & ABUF_EN;
    clr_req   = grant ? (4'b0001 << winner) : 4'b0000;
    // A request coinciding with its own clear re-queues instead of overrunning.
    ovr_set   = set_req & pending_q & ~clr_req;
    pending_d = ABUF_EN & (set_req | (pending_q & ~clr_req));
    ovr_d     = ovr_set | (ovr_q & ~{4{OVR_CLR}});
    to_d      = to_set | (to_q & ~OVR_CLR);
    req_d     = (state_d == StReq);
    sack_d    = (state_d == StSack) ? (4'b0001 << ch_d) : 4'b0000;
  end

  always_ff @(posedge DSPCLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      pending_q <= 4'b0000;
      ptr_q     <= 2'd3;
      ch_q      <= 2'd0;
      cnt_q     <= 4'd0;
      req_q     <= 1'b0;
      sack_q    <= 4'b0000;
      irq_q     <= 4'b0000;
      ovr_q     <= 4'b0000;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      sack_q    <= sack_d;
      irq_q     <= irq_d;
      ovr_q     <= ovr_d;
      to_q      <= to_d;
    end
  end

  assign STEAL_REQ = req_q;
  assign R0sack    = sack_q[0];
  assign T0sack    = sack_q[1];
  assign R1sack    = sack_q[2];
  assign T1sack    = sack_q[3];
  assign ABUF_IRQ  = irq_q;
  assign OVR       = ovr_q;
  assign STEAL_TO  = to_q;

endmodule
